// File: rtl/inert_pkg.sv
// Shared types and helpers for the inertial integrator block.
// State enum, default tuning constants and the 16-bit signed saturation helper.
package inert_pkg;

  typedef enum logic {
    CAL = 1'b0,
    RUN = 1'b1
  } state_e;

  localparam int          CAL_SHIFT_DFLT   = 8;
  localparam logic [15:0] AZ_OFFSET_DFLT   = 16'h00A0;
  localparam int          ACC_GAIN_DFLT    = 327;
  localparam int          FUSION_STEP_DFLT = 1024;

  // Clamp a 17-bit signed difference into the 16-bit signed range.
  function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
    if (v > 17'sd32767) begin
      return 16'sh7FFF;
    end else if (v < -17'sd32768) begin
      return 16'sh8000;
    end else begin
      return v[15:0];
    end
  endfunction

endpackage

// File: rtl/inertial_integrator_if.sv
// Sample/result bus between the inertial sensor front end and the integrator.
// master = sensor side (drives raw samples), slave = integrator.
interface inertial_integrator_if;
  logic        vld_raw;
  logic [15:0] ptch_rt_raw;
  logic [15:0] AZ;
  logic        cal_req;
  logic [15:0] ptch;
  logic [15:0] ptch_rt;
  logic        vld;
  logic        cal_done;

  modport master (
    output vld_raw, ptch_rt_raw, AZ, cal_req,
    input  ptch, ptch_rt, vld, cal_done
  );

  modport slave (
    input  vld_raw, ptch_rt_raw, AZ, cal_req,
    output ptch, ptch_rt, vld, cal_done
  );
endinterface

// File: rtl/inert_cal.sv
// Gyro bias averager: sums 2^CAL_SHIFT raw rate samples and stores the mean.
// The stored offset survives a restart so RUN keeps a valid bias until the
// new average is ready.
module inert_cal
  import inert_pkg::*;
#(
  parameter int CAL_SHIFT = CAL_SHIFT_DFLT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        sample_vld_i,
  input  logic [15:0] sample_i,
  output logic        done_o,
  output logic [15:0] offset_o
);

  localparam int ACC_W = 16 + CAL_SHIFT;

  logic [CAL_SHIFT-1:0]    cal_cnt_q, cal_cnt_d;
  logic signed [ACC_W-1:0] cal_acc_q, cal_acc_d;
  logic signed [ACC_W-1:0] acc_sum;
  logic [15:0]             offset_q, offset_d;
  logic                    last_w;

  assign acc_sum  = cal_acc_q + {{CAL_SHIFT{sample_i[15]}}, sample_i};
  assign last_w   = sample_vld_i && !start_i && (cal_cnt_q == '1);
  assign done_o   = last_w;
  assign offset_o = offset_q;

  // Next-state: restart clears the average, the final sample latches the mean.
  always_comb begin
    cal_cnt_d = cal_cnt_q;
    cal_acc_d = cal_acc_q;
    offset_d  = offset_q;
    if (start_i) begin
      cal_cnt_d = '0;
      cal_acc_d = '0;
    end else if (sample_vld_i) begin
      cal_cnt_d = cal_cnt_q + 1'b1;
      if (last_w) begin
        cal_acc_d = '0;
        offset_d  = 16'(acc_sum >>> CAL_SHIFT);
      end else begin
        cal_acc_d = acc_sum;
      end
    end
  end

  // Calibration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cal_cnt_q <= '0;
      cal_acc_q <= '0;
      offset_q  <= '0;
    end else begin
      cal_cnt_q <= cal_cnt_d;
      cal_acc_q <= cal_acc_d;
      offset_q  <= offset_d;
    end
  end

endmodule

// File: rtl/inertial_integrator.sv
// Pitch integrator feeding the balance PID.
// Calibrates gyro bias, integrates bias-corrected rate into a 27-bit pitch
// accumulator and optionally nudges it toward the accelerometer pitch.
// Build option: define INERT_FUSION_EN to enable accel fusion; without it
// AZ is ignored and the integrator is pure gyro.
//
// state | meaning
// ------+-------------------------------------------------------------
// CAL   | averaging raw gyro samples for bias; outputs held at 0, no vld
// RUN   | each vld_raw updates ptch_rt/ptch and pulses vld next cycle
module inertial_integrator
  import inert_pkg::*;
#(
  parameter int          CAL_SHIFT   = CAL_SHIFT_DFLT,
  parameter logic [15:0] AZ_OFFSET   = AZ_OFFSET_DFLT,
  parameter int          ACC_GAIN    = ACC_GAIN_DFLT,
  parameter int          FUSION_STEP = FUSION_STEP_DFLT
) (
  input logic                  clk,
  input logic                  rst_n,
  inertial_integrator_if.slave bus
);

  state_e             state_q;
  logic signed [26:0] ptch_int_q;
  logic [15:0]        ptch_rt_q;
  logic               vld_q;
  logic               cal_done_q;

  logic               cal_fin;
  logic [15:0]        offset;
  logic               cal_sample;
  logic signed [16:0] rt_diff;
  logic signed [15:0] rt_sat;
  logic signed [15:0] ptch_s;
  logic signed [26:0] fusion_term;
  logic signed [26:0] ptch_int_d;

  // Samples taken during a restart are dropped, so cal_req masks the strobe.
  assign cal_sample = bus.vld_raw && !bus.cal_req && (state_q == CAL);

  inert_cal #(
    .CAL_SHIFT (CAL_SHIFT)
  ) u_cal (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (bus.cal_req),
    .sample_vld_i (cal_sample),
    .sample_i     (bus.ptch_rt_raw),
    .done_o       (cal_fin),
    .offset_o     (offset)
  );

  assign ptch_s = ptch_int_q[26:11];

`ifdef INERT_FUSION_EN
  logic [15:0]        az_comp;
  logic signed [25:0] prod;
  logic signed [15:0] ptch_acc;
  logic               unused_prod_lsb;

  assign az_comp         = bus.AZ - AZ_OFFSET;
  assign prod            = $signed({{10{az_comp[15]}}, az_comp}) * $signed(26'(ACC_GAIN));
  assign ptch_acc        = {{3{prod[25]}}, prod[25:13]};
  assign unused_prod_lsb = ^prod[12:0];

  // Drift correction: step the integrator one notch toward the accel pitch.
  always_comb begin
    fusion_term = '0;
    if (ptch_acc > ptch_s) begin
      fusion_term = 27'(FUSION_STEP);
    end else if (ptch_acc < ptch_s) begin
      fusion_term = 27'(-FUSION_STEP);
    end
  end
`else
  logic unused_az;

  assign unused_az   = ^{bus.AZ, AZ_OFFSET, 16'(ACC_GAIN), 16'(FUSION_STEP)};
  assign fusion_term = '0;
`endif

  // Bias-corrected rate, saturated, and the integrator's next value.
  always_comb begin
    rt_diff    = $signed({bus.ptch_rt_raw[15], bus.ptch_rt_raw}) - $signed({offset[15], offset});
    rt_sat     = sat16(rt_diff);
    ptch_int_d = ptch_int_q - {{11{rt_sat[15]}}, rt_sat} + fusion_term;
  end

  // Control FSM with registered outputs; cal_req wins over everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CAL;
      ptch_int_q <= '0;
      ptch_rt_q  <= '0;
      vld_q      <= 1'b0;
      cal_done_q <= 1'b0;
    end else if (bus.cal_req) begin
      state_q    <= CAL;
      ptch_int_q <= '0;
      ptch_rt_q  <= '0;
      vld_q      <= 1'b0;
      cal_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        CAL: begin
          vld_q <= 1'b0;
          if (cal_fin) begin
            state_q    <= RUN;
            cal_done_q <= 1'b1;
          end
        end
        RUN: begin
          vld_q <= bus.vld_raw;
          if (bus.vld_raw) begin
            ptch_rt_q  <= rt_sat;
            ptch_int_q <= ptch_int_d;
          end
        end
        default: begin
          state_q <= CAL;
          vld_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ptch     = ptch_s;
  assign bus.ptch_rt  = ptch_rt_q;
  assign bus.vld      = vld_q;
  assign bus.cal_done = cal_done_q;

endmodule

// File: tb/tb_inertial_integrator.sv
// Directed bench for inertial_integrator (CAL_SHIFT = 2).
// Covers both builds: expectations that depend on accel fusion follow
// INERT_FUSION_EN.
module tb_inertial_integrator;

`ifdef INERT_FUSION_EN
  localparam bit FUS = 1'b1;
`else
  localparam bit FUS = 1'b0;
`endif

  typedef struct {
    logic        vr;
    logic [15:0] raw;
    logic [15:0] az;
    logic        cr;
    logic [15:0] e_ptch;
    logic [15:0] e_rt;
    logic        e_vld;
    logic        e_done;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;
  vec_t tbl[14];

  inertial_integrator_if bus ();

  inertial_integrator #(.CAL_SHIFT(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vr, input logic [15:0] raw, input logic [15:0] az, input logic cr);
    bus.vld_raw     = vr;
    bus.ptch_rt_raw = raw;
    bus.AZ          = az;
    bus.cal_req     = cr;
    step();
    bus.vld_raw = 1'b0;
    bus.cal_req = 1'b0;
  endtask

  initial begin
    // idx: vr raw az cr | ptch rt vld done
    tbl[0]  = '{1'b1, 16'h0010, 16'h00A0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 16'h0010, 16'h00A0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 16'h0010, 16'h00A0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 16'h0010, 16'h00A0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 16'h0010, 16'h00A0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 16'h0010, 16'h00A0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 16'h0010, 16'h00A0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 16'h0010, 16'h00A0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 16'h0410, 16'h00A0, 1'b0, 16'hFFFF, 16'h0400, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 16'h0010, 16'h00A0, 1'b0, FUS ? 16'h0000 : 16'hFFFF, 16'h0000, 1'b1, 1'b1};
    tbl[10] = '{1'b1, 16'h0010, 16'h10A0, 1'b0, FUS ? 16'h0000 : 16'hFFFF, 16'h0000, 1'b1, 1'b1};
    tbl[11] = '{1'b1, 16'h0010, 16'h10A0, 1'b0, FUS ? 16'h0001 : 16'hFFFF, 16'h0000, 1'b1, 1'b1};
    tbl[12] = '{1'b1, 16'h0410, 16'h00A0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 16'h0410, 16'h00A0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};

    bus.vld_raw     = 1'b0;
    bus.ptch_rt_raw = 16'h0000;
    bus.AZ          = 16'h00A0;
    bus.cal_req     = 1'b0;
    rst_n           = 1'b0;
    #23;
    chk("rst_ptch", bus.ptch, 16'h0000);
    chk("rst_rt", bus.ptch_rt, 16'h0000);
    chk("rst_vld", 16'(bus.vld), 16'h0000);
    chk("rst_done", 16'(bus.cal_done), 16'h0000);
    rst_n = 1'b1;
    step();

    // Calibration, steady state, integration, fusion and cal_req-with-sample.
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].vr, tbl[i].raw, tbl[i].az, tbl[i].cr);
      chk($sformatf("v%0d_ptch", i), bus.ptch, tbl[i].e_ptch);
      chk($sformatf("v%0d_rt", i), bus.ptch_rt, tbl[i].e_rt);
      chk($sformatf("v%0d_vld", i), 16'(bus.vld), 16'(tbl[i].e_vld));
      chk($sformatf("v%0d_done", i), 16'(bus.cal_done), 16'(tbl[i].e_done));
    end

    // Recalibration needs four fresh samples after the request.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'h0010, 16'h00A0, 1'b0);
      chk($sformatf("recal%0d_done", i), 16'(bus.cal_done), (i == 3) ? 16'h0001 : 16'h0000);
      chk($sformatf("recal%0d_vld", i), 16'(bus.vld), 16'h0000);
    end

`ifndef INERT_FUSION_EN
    // Pure gyro: 1024 samples of rate 0x0800 integrate to -1024 pitch.
    for (int i = 0; i < 1024; i++) begin
      drive(1'b1, 16'h0810, 16'h0000, 1'b0);
      chk("gyro_vld", 16'(bus.vld), 16'h0001);
    end
    chk("gyro_rt", bus.ptch_rt, 16'h0800);
    chk("gyro_ptch", bus.ptch, 16'hFC00);
    drive(1'b0, 16'h0810, 16'h0000, 1'b0);
    chk("gyro_idle_vld", 16'(bus.vld), 16'h0000);
    chk("gyro_hold_ptch", bus.ptch, 16'hFC00);
`endif

    // Positive saturation with a -256 bias.
    drive(1'b0, 16'h0000, 16'h00A0, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 16'hFF00, 16'h00A0, 1'b0);
    drive(1'b1, 16'h7FFF, 16'h00A0, 1'b0);
    chk("sat_pos", bus.ptch_rt, 16'h7FFF);

    // Negative saturation with a +256 bias.
    drive(1'b0, 16'h0000, 16'h00A0, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 16'h0100, 16'h00A0, 1'b0);
    drive(1'b1, 16'h8000, 16'h00A0, 1'b0);
    chk("sat_neg", bus.ptch_rt, 16'h8000);

    // Async reset part-way through calibration restarts the sample count.
    drive(1'b0, 16'h0000, 16'h00A0, 1'b1);
    drive(1'b1, 16'h0020, 16'h00A0, 1'b0);
    drive(1'b1, 16'h0020, 16'h00A0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_cal_rt", bus.ptch_rt, 16'h0000);
    chk("arst_cal_done", 16'(bus.cal_done), 16'h0000);
    #2 rst_n = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'h0020, 16'h00A0, 1'b0);
      chk($sformatf("arst_recal%0d_done", i), 16'(bus.cal_done), (i == 3) ? 16'h0001 : 16'h0000);
    end
    drive(1'b1, 16'h0021, 16'h00A0, 1'b0);
    chk("arst_off_rt", bus.ptch_rt, 16'h0001);
    chk("arst_off_vld", 16'(bus.vld), 16'h0001);

    // Async reset in RUN clears outputs without waiting for a clock.
    #3 rst_n = 1'b0;
    #1;
    chk("arst_run_rt", bus.ptch_rt, 16'h0000);
    chk("arst_run_done", 16'(bus.cal_done), 16'h0000);
    chk("arst_run_vld", 16'(bus.vld), 16'h0000);
    #2 rst_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
